// File: rtl/control_unit.sv
// control_unit: hardwired T0-T5 instruction sequencer for the simple CPU datapath.
// Outputs are registered from the next state, so they always reflect the current state.
module control_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stop,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        Cout,
   output logic        Rout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Rin,
   output logic        IncPC,
   output logic        Read,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic [4:0]  operation,
   output logic        Run
);

   typedef enum logic [3:0] {
      RESET_S = 4'd0,
      T0      = 4'd1,
      T1      = 4'd2,
      T2      = 4'd3,
      R3      = 4'd4,
      R4      = 4'd5,
      R5      = 4'd6,
      I3      = 4'd7,
      I4      = 4'd8,
      I5      = 4'd9,
      HALT_S  = 4'd10
   } state_t;

   typedef struct packed {
      logic       pc_out;
      logic       zlow_out;
      logic       mdr_out;
      logic       c_out;
      logic       r_out;
      logic       mar_in;
      logic       pc_in;
      logic       mdr_in;
      logic       ir_in;
      logic       y_in;
      logic       z_in;
      logic       r_in;
      logic       inc_pc;
      logic       read;
      logic       gra;
      logic       grb;
      logic       grc;
      logic [4:0] alu_op;
   } strobes_t;

   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_NOP  = 5'b11010;

   function automatic logic is_r_format(input logic [4:0] op);
      return (op >= 5'b00011) && (op <= 5'b01010);
   endfunction

   function automatic logic is_i_format(input logic [4:0] op);
      return (op >= OP_ADDI) && (op <= OP_ORI);
   endfunction

   function automatic logic [4:0] i_alu_op(input logic [4:0] op);
      logic [4:0] alu;
      case (op)
         OP_ADDI: alu = 5'b00101;
         OP_ANDI: alu = 5'b00011;
         OP_ORI:  alu = 5'b00100;
         default: alu = 5'b00000;
      endcase
      return alu;
   endfunction

   function automatic strobes_t decode_strobes(input state_t s, input logic [4:0] op);
      strobes_t st;
      st = '0;
      case (s)
         T0: begin
            st.pc_out = 1'b1;
            st.mar_in = 1'b1;
            st.inc_pc = 1'b1;
            st.z_in   = 1'b1;
         end
         T1: begin
            st.zlow_out = 1'b1;
            st.pc_in    = 1'b1;
            st.read     = 1'b1;
            st.mdr_in   = 1'b1;
         end
         T2: begin
            st.mdr_out = 1'b1;
            st.ir_in   = 1'b1;
         end
         R3, I3: begin
            st.grb   = 1'b1;
            st.r_out = 1'b1;
            st.y_in  = 1'b1;
         end
         R4: begin
            st.grc    = 1'b1;
            st.r_out  = 1'b1;
            st.z_in   = 1'b1;
            st.alu_op = op;
         end
         I4: begin
            st.c_out  = 1'b1;
            st.z_in   = 1'b1;
            st.alu_op = op;
         end
         R5, I5: begin
            st.zlow_out = 1'b1;
            st.gra      = 1'b1;
            st.r_in     = 1'b1;
         end
         default: st = '0;
      endcase
      return st;
   endfunction

   state_t     state_r;
   state_t     next_s;
   state_t     boundary_s;
   logic [4:0] opcode_r;
   logic [4:0] exec_op_s;
   strobes_t   strobes_r;
   logic       run_r;
   logic       ir_unused_s;

   // Only the opcode field is decoded here; the register and constant fields go to the datapath.
   assign ir_unused_s = &{1'b0, IR[26:0]};

   // Next-state selection; Stop diverts every return to T0 into HALT_S.
   always_comb begin
      if (Stop) begin
         boundary_s = HALT_S;
      end else begin
         boundary_s = T0;
      end
      next_s = state_r;
      case (state_r)
         RESET_S: next_s = boundary_s;
         T0:      next_s = T1;
         T1:      next_s = T2;
         T2: begin
            if (is_r_format(IR[31:27])) begin
               next_s = R3;
            end else if (is_i_format(IR[31:27])) begin
               next_s = I3;
            end else if (IR[31:27] == OP_NOP) begin
               next_s = boundary_s;
            end else begin
               next_s = HALT_S;
            end
         end
         R3:      next_s = R4;
         R4:      next_s = R5;
         R5:      next_s = boundary_s;
         I3:      next_s = I4;
         I4:      next_s = I5;
         I5:      next_s = boundary_s;
         HALT_S:  next_s = HALT_S;
         default: next_s = HALT_S;
      endcase
   end

   // ALU code for the upcoming execute cycle, taken from the opcode latched at the end of T2.
   always_comb begin
      exec_op_s = 5'b00000;
      if (next_s == R4) begin
         exec_op_s = opcode_r;
      end else if (next_s == I4) begin
         exec_op_s = i_alu_op(opcode_r);
      end else begin
         exec_op_s = 5'b00000;
      end
   end

   // State, latched opcode and registered strobes; Reset overrides everything.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r   <= RESET_S;
         opcode_r  <= 5'b00000;
         strobes_r <= decode_strobes(RESET_S, 5'b00000);
         run_r     <= 1'b1;
      end else begin
         state_r <= next_s;
         if (state_r == T2) begin
            opcode_r <= IR[31:27];
         end else begin
            opcode_r <= opcode_r;
         end
         strobes_r <= decode_strobes(next_s, exec_op_s);
         run_r     <= (next_s != HALT_S);
      end
   end

   assign PCout     = strobes_r.pc_out;
   assign Zlowout   = strobes_r.zlow_out;
   assign MDRout    = strobes_r.mdr_out;
   assign Cout      = strobes_r.c_out;
   assign Rout      = strobes_r.r_out;
   assign MARin     = strobes_r.mar_in;
   assign PCin      = strobes_r.pc_in;
   assign MDRin     = strobes_r.mdr_in;
   assign IRin      = strobes_r.ir_in;
   assign Yin       = strobes_r.y_in;
   assign Zin       = strobes_r.z_in;
   assign Rin       = strobes_r.r_in;
   assign IncPC     = strobes_r.inc_pc;
   assign Read      = strobes_r.read;
   assign Gra       = strobes_r.gra;
   assign Grb       = strobes_r.grb;
   assign Grc       = strobes_r.grc;
   assign operation = strobes_r.alu_op;
   assign Run       = run_r;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the simple CPU datapath. It generates the per-cycle strobes that drive the datapath's bus, register and memory-read handshakes, which benches currently sequence by hand. It walks a fixed T0–T5 instruction cycle: a three-cycle fetch, then a three-cycle execute decoded from the instruction register. It sits beside `datapath`, taking `IR` from it and driving its control inputs. Register selection is by Gra/Grb/Grc plus Rin/Rout; the datapath's select/encode logic decodes these.

## Interface
Parameters:
- none.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Stop`  in  1  level request to halt at the next instruction boundary.
- `IR`  in  32  instruction register contents from the datapath.
- `PCout, Zlowout, MDRout, Cout`  out  1 each  bus-drive strobes.
- `Rout`  out  1  bus-drive strobe for the general register named by the selected Gr field.
- `MARin, PCin, MDRin, IRin, Yin, Zin`  out  1 each  register load strobes.
- `Rin`  out  1  load strobe for the general register named by the selected Gr field.
- `IncPC`  out  1  makes the ALU compute PC+1 during T0.
- `Read`  out  1  memory read into MDR.
- `Gra, Grb, Grc`  out  1 each  select IR field Ra, Rb or Rc as the general register.
- `operation`  out  5  ALU operation code.
- `Run`  out  1  high unless halted.

## Operation
- IR fields:
  - opcode = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
  - C = IR[18:0]; the datapath sign-extends C onto the bus under `Cout`.
- Opcode classes:
  - R-format: 00011–01010 (and, or, add, sub, shr, shl, ror, rol). `operation` = opcode.
  - I-format: 01011 addi, 01100 andi, 01101 ori. `operation` = 00101, 00011 and 00100 respectively.
  - 11010: nop.
  - 11011: halt.
  - Every other opcode is treated as halt.
- Moore machine; outputs are a pure function of the current state. Any strobe not listed for a state is 0, and `operation` = 00000 outside T4.
- States and asserted outputs:
  - RESET_S: nothing asserted.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - R3: Grb, Rout, Yin.
  - R4: Grc, Rout, Zin, operation.
  - R5: Zlowout, Gra, Rin.
  - I3: Grb, Rout, Yin.
  - I4: Cout, Zin, operation.
  - I5: Zlowout, Gra, Rin.
  - HALT_S: nothing asserted; Run = 0.
- Transitions:
  - RESET_S → T0.
  - T0 → T1 → T2.
  - T2 → R3, I3, T0 (nop) or HALT_S (halt or illegal opcode), decoded from `IR` sampled in T2.
  - R3 → R4 → R5 → T0.
  - I3 → I4 → I5 → T0.
  - HALT_S → HALT_S.
- Stop: on any transition whose target is T0, if `Stop` = 1 the target becomes HALT_S instead. `Stop` is ignored elsewhere.
- The T4 opcode is taken from a 5-bit copy of the opcode latched at the end of T2, so IR changes after T2 do not affect execute.

## Timing
- Reset has priority over every transition. With `Reset` high at a rising edge, the next state is RESET_S and the latched opcode clears to 0, from any state, mid-instruction included.
- Reset values: every strobe 0, `operation` = 00000, `Run` = 1.
- Latencies:
  - Reset release to first T0: 1 cycle.
  - R- and I-format instructions: 6 cycles, T0 to T0.
  - nop: 3 cycles.
- Memory read is single-cycle: data is valid at the T1 edge.
- HALT_S is exited only by `Reset`.
- Exactly one Gr select is high in any cycle where Rin or Rout is high, and none otherwise.

## Test plan
- Reset held 2 cycles, then released → all outputs 0 with Run = 1, then T0 strobes (PCout, MARin, IncPC, Zin) on the next cycle.
- IR = 32'h2A2B8000 (add, Ra=4, Rb=5, Rc=7) → T3: Grb/Rout/Yin; T4: Grc/Rout/Zin with operation = 00101; T5: Zlowout/Gra/Rin; T0 again 6 cycles after the previous T0.
- IR with opcode 01100 (andi) → T4 asserts Cout/Zin with operation = 00011 and no Rout.
- nop opcode 11010 → T0 returns 3 cycles after the previous T0; no Rin in between.
- `Stop` = 1 during R4 → R5 completes with Rin, next state HALT_S, Run = 0 and held there for 10 cycles.
- `Reset` asserted in R4 → next cycle all strobes 0 and operation = 00000; T0 one cycle after release.
